// File: rtl/window_serializer.sv
// Parallel-to-serial window replay: takes an N-element window in one handshake and
// streams it oldest-first, one element per cycle, with index and last flag.
module window_serializer #(
    parameter int W = 16,
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*N-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IW-1:0]  out_idx,
    output logic           out_last,
    output logic           busy
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic          load;
    logic [W-1:0]  win [N];

    logic accept, xfer;

    assign busy      = (state == EMIT);
    assign out_valid = busy;
    assign out_idx   = idx;
    assign out_last  = busy && (idx == IW'(N - 1));
    assign out_data  = busy ? win[idx] : '0;
    assign in_ready  = !rst && ((state == IDLE) || (busy && out_ready && out_last));
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: the window storage is reset on purpose so out_data reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < N; i++) win[i] <= in_data[i*W +: W];
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EMIT;
                    idx_next   = '0;
                    load       = 1'b1;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (!out_last) begin
                        idx_next = idx + IW'(1);
                    end else if (accept) begin
                        // Seamless hand-over to the next window: no bubble.
                        idx_next = '0;
                        load     = 1'b1;
                    end else begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_window_serializer.sv
// Directed self-checking bench for window_serializer: inputs change on the falling
// edge, outputs are sampled 1 ns later, well away from the rising edge.
module tb_window_serializer;

    localparam int W = 16;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W*N-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    window_serializer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W*N-1:0] win4(input logic [15:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic expect_elem(input string tag, input logic [15:0] d, input int i,
                               input bit rdy);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".idx"}, 32'(out_idx), 32'(i));
        check({tag, ".last"}, 32'(out_last), 32'(i == N - 1));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".idx"}, 32'(out_idx), 32'd0);
        check({tag, ".last"}, 32'(out_last), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nvalid;

        // 1: reset state, in_ready low while rst is high
        #2;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.idx", 32'(out_idx), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        expect_idle("rel");

        // 2: single window, consumer always ready
        cyc();
        in_data = win4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t2.accept_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            expect_elem("t2", 16'(i + 1), i, i == N - 1);
        end
        cyc();
        #1;
        expect_idle("t2.end");

        // 3: back-to-back windows with in_valid held, no bubble between them
        in_data = win4(16'h0010, 16'h0011, 16'h0012, 16'h0013);
        in_valid = 1'b1;
        #1;
        check("t3.ready_before", 32'(in_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            cyc();
            in_data = win4(16'h0020, 16'h0021, 16'h0022, 16'h0023);
            #1;
            expect_elem("t3a", 16'h0010 + 16'(i), i, i == N - 1);
        end
        for (int i = 0; i < N; i++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            expect_elem("t3b", 16'h0020 + 16'(i), i, i == N - 1);
        end
        cyc();
        #1;
        expect_idle("t3.end");

        // 4: backpressure for 3 cycles at index 1
        in_data = win4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        in_valid = 1'b1;
        nvalid = 0;
        cyc();
        in_valid = 1'b0;
        #1;
        expect_elem("t4.e0", 16'h0001, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            out_ready = (k == 3);
            #1;
            expect_elem("t4.hold", 16'h0002, 1, 1'b0);
        end
        cyc();
        #1;
        expect_elem("t4.e2", 16'h0003, 2, 1'b0);
        cyc();
        #1;
        expect_elem("t4.e3", 16'h0004, 3, 1'b1);
        cyc();
        #1;
        expect_idle("t4.end");
        nvalid = 0;
        // replay the same sequence only counting valid cycles
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            in_valid = 1'b0;
            out_ready = !(k >= 1 && k <= 3);
            #1;
            if (out_valid) nvalid++;
        end
        check("t4.valid_cycles", 32'(nvalid), 32'd7);
        out_ready = 1'b1;

        // 5: in_data changes while busy are ignored
        in_data = win4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        in_valid = 1'b1;
        cyc();
        in_data = win4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        #1;
        expect_elem("t5.e0", 16'h0001, 0, 1'b0);
        for (int i = 1; i < N; i++) begin
            cyc();
            #1;
            expect_elem("t5.cur", 16'(i + 1), i, i == N - 1);
        end
        for (int i = 0; i < N; i++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            expect_elem("t5.next", 16'hFFFF, i, i == N - 1);
        end
        cyc();
        #1;
        expect_idle("t5.end");

        // 6: reset mid-window drops the remaining elements
        in_data = win4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        #1;
        expect_elem("t6.e0", 16'h0001, 0, 1'b0);
        cyc();
        #1;
        expect_elem("t6.e1", 16'h0002, 1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6.rst.valid", 32'(out_valid), 32'd0);
        check("t6.rst.data", 32'(out_data), 32'd0);
        check("t6.rst.busy", 32'(busy), 32'd0);
        check("t6.rst.in_ready", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        expect_idle("t6.rel");
        check("t6.rel.data", 32'(out_data), 32'd0);
        cyc();
        #1;
        expect_idle("t6.quiet");
        in_data = win4(16'h000A, 16'h000B, 16'h000C, 16'h000D);
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            expect_elem("t6.new", 16'h000A + 16'(i), i, i == N - 1);
        end
        cyc();
        #1;
        expect_idle("t6.end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
